// File: rtl/sparrow_pkg.sv
// rtl/sparrow_pkg.sv - shared types for the sparrow core and its memory arbiter
package sparrow_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/sparrow_arb_prio.sv
// rtl/sparrow_arb_prio.sv - dmem-first priority picker with a bounded dmem run
module sparrow_arb_prio
    import sparrow_pkg::*;
#(
    parameter int MAX_DMEM_RUN = 4,
    parameter int RUN_CNT_W    = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_imem_req,
    input  logic       i_dmem_req,
    input  logic       i_grant,
    output arb_owner_e o_winner
);

    localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(MAX_DMEM_RUN);

    logic [RUN_CNT_W-1:0] run_cnt_q;
    logic [RUN_CNT_W-1:0] run_cnt_d;
    logic                 run_full;

    // dmem wins unless a waiting fetch has already been overtaken MAX_DMEM_RUN times
    always_comb begin
        o_winner = OWN_IMEM;
        run_full = (run_cnt_q == RUN_MAX);
        if (i_dmem_req && !(i_imem_req && run_full)) begin
            o_winner = OWN_DMEM;
        end
    end

    // Count dmem wins that overtook a waiting fetch; any other grant restarts the run
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (i_grant) begin
            if ((o_winner == OWN_DMEM) && i_imem_req) begin
                run_cnt_d = run_full ? run_cnt_q : run_cnt_q + RUN_CNT_W'(1);
            end else begin
                run_cnt_d = '0;
            end
        end
    end

    // Run counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule

// File: rtl/sparrow_mem_arbiter.sv
// rtl/sparrow_mem_arbiter.sv - shares one memory port between sparrow fetch and data ports
module sparrow_mem_arbiter
    import sparrow_pkg::*;
#(
    parameter int MAX_DMEM_RUN = 4,
    parameter int RUN_CNT_W    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_gnt,
    output logic        o_imem_rvalid,
    output logic [31:0] o_imem_rd_data,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic [1:0]  i_dmem_byte_en,
    input  logic        i_dmem_wr_en,
    input  logic [31:0] i_dmem_wr_data,
    output logic        o_dmem_gnt,
    output logic        o_dmem_rvalid,
    output logic [31:0] o_dmem_rd_data,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic [1:0]  o_mem_byte_en,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_wr_data,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rd_data
);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_byte_en_q, mem_byte_en_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [31:0] mem_wr_data_q, mem_wr_data_d;
    logic        imem_rvalid_q, imem_rvalid_d;
    logic [31:0] imem_rd_data_q, imem_rd_data_d;
    logic        dmem_rvalid_q, dmem_rvalid_d;
    logic [31:0] dmem_rd_data_q, dmem_rd_data_d;

    arb_owner_e  winner;
    logic        arb_go;
    logic        resp_done;

    sparrow_arb_prio #(
        .MAX_DMEM_RUN (MAX_DMEM_RUN),
        .RUN_CNT_W    (RUN_CNT_W)
    ) u_prio (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_imem_req (i_imem_req),
        .i_dmem_req (i_dmem_req),
        .i_grant    (arb_go),
        .o_winner   (winner)
    );

    // Next-state, command capture and response routing
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        mem_byte_en_d  = mem_byte_en_q;
        mem_wr_en_d    = mem_wr_en_q;
        mem_wr_data_d  = mem_wr_data_q;
        imem_rvalid_d  = 1'b0;
        imem_rd_data_d = imem_rd_data_q;
        dmem_rvalid_d  = 1'b0;
        dmem_rd_data_d = dmem_rd_data_q;
        arb_go         = 1'b0;
        resp_done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_imem_req || i_dmem_req) begin
                    arb_go    = 1'b1;
                    owner_d   = winner;
                    mem_req_d = 1'b1;
                    state_d   = REQ;
                    if (winner == OWN_DMEM) begin
                        mem_addr_d    = i_dmem_addr;
                        mem_byte_en_d = i_dmem_byte_en;
                        mem_wr_en_d   = i_dmem_wr_en;
                        mem_wr_data_d = i_dmem_wr_data;
                    end else begin
                        mem_addr_d    = i_imem_addr;
                        mem_byte_en_d = WORD;
                        mem_wr_en_d   = 1'b0;
                        mem_wr_data_d = '0;
                    end
                end
            end
            REQ: begin
                // A response without an accept is a memory protocol error and is dropped
                if (i_mem_gnt) begin
                    mem_req_d = 1'b0;
                    resp_done = i_mem_rvalid;
                    state_d   = i_mem_rvalid ? IDLE : RESP;
                end
            end
            RESP: begin
                if (i_mem_rvalid) begin
                    resp_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resp_done) begin
            if (owner_q == OWN_DMEM) begin
                dmem_rvalid_d  = 1'b1;
                dmem_rd_data_d = mem_wr_en_q ? 32'h0 : i_mem_rd_data;
            end else begin
                imem_rvalid_d  = 1'b1;
                imem_rd_data_d = i_mem_rd_data;
            end
        end
    end

    // State, command and response registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IMEM;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_byte_en_q  <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_wr_data_q  <= '0;
            imem_rvalid_q  <= 1'b0;
            imem_rd_data_q <= '0;
            dmem_rvalid_q  <= 1'b0;
            dmem_rd_data_q <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_byte_en_q  <= mem_byte_en_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_wr_data_q  <= mem_wr_data_d;
            imem_rvalid_q  <= imem_rvalid_d;
            imem_rd_data_q <= imem_rd_data_d;
            dmem_rvalid_q  <= dmem_rvalid_d;
            dmem_rd_data_q <= dmem_rd_data_d;
        end
    end

    // Upstream accepts follow the memory accept in the same cycle
    assign o_imem_gnt     = (state_q == REQ) && i_mem_gnt && (owner_q == OWN_IMEM);
    assign o_dmem_gnt     = (state_q == REQ) && i_mem_gnt && (owner_q == OWN_DMEM);
    assign o_imem_rvalid  = imem_rvalid_q;
    assign o_imem_rd_data = imem_rd_data_q;
    assign o_dmem_rvalid  = dmem_rvalid_q;
    assign o_dmem_rd_data = dmem_rd_data_q;
    assign o_mem_req      = mem_req_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_byte_en  = mem_byte_en_q;
    assign o_mem_wr_en    = mem_wr_en_q;
    assign o_mem_wr_data  = mem_wr_data_q;

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// tb/tb_sparrow_mem_arbiter.sv - self-checking bench for sparrow_mem_arbiter
module tb_sparrow_mem_arbiter;

    localparam int MAX_RUN = 4;

    logic        i_clk, i_reset;
    logic        i_imem_req;
    logic [31:0] i_imem_addr;
    logic        o_imem_gnt, o_imem_rvalid;
    logic [31:0] o_imem_rd_data;
    logic        i_dmem_req;
    logic [31:0] i_dmem_addr;
    logic [1:0]  i_dmem_byte_en;
    logic        i_dmem_wr_en;
    logic [31:0] i_dmem_wr_data;
    logic        o_dmem_gnt, o_dmem_rvalid;
    logic [31:0] o_dmem_rd_data;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic [1:0]  o_mem_byte_en;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_wr_data;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rd_data;

    int total = 0;
    int bad   = 0;

    // memory model controls
    int          mem_gnt_delay = 0;
    int          mem_rv_delay  = 1;
    bit          mem_rand      = 0;
    bit          fixed_en      = 0;
    logic [31:0] fixed_data    = 32'h0;

    // observation results
    int          ob_mreq, ob_gnt_i, ob_gnt_d, ob_rv_i, ob_rv_d;
    int          ob_gntidx, ob_gntidx_last, ob_rvidx_i, ob_rvidx_d, ob_unstable;
    logic [31:0] ob_data_i, ob_data_d;
    logic [66:0] snap_q[$];
    int          order_q[$];
    int          dmem_more = 0;

    sparrow_mem_arbiter #(.MAX_DMEM_RUN(MAX_RUN), .RUN_CNT_W(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr),
        .o_imem_gnt(o_imem_gnt), .o_imem_rvalid(o_imem_rvalid), .o_imem_rd_data(o_imem_rd_data),
        .i_dmem_req(i_dmem_req), .i_dmem_addr(i_dmem_addr), .i_dmem_byte_en(i_dmem_byte_en),
        .i_dmem_wr_en(i_dmem_wr_en), .i_dmem_wr_data(i_dmem_wr_data),
        .o_dmem_gnt(o_dmem_gnt), .o_dmem_rvalid(o_dmem_rvalid), .o_dmem_rd_data(o_dmem_rd_data),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_byte_en(o_mem_byte_en),
        .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_data(o_mem_wr_data),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rd_data(i_mem_rd_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (fixed_en) return fixed_data;
        return (a ^ 32'h5A5A0F0F) + {a[15:0], a[31:16]};
    endfunction

    function automatic logic [135:0] all_outs();
        return {o_imem_gnt, o_imem_rvalid, o_imem_rd_data, o_dmem_gnt, o_dmem_rvalid,
                o_dmem_rd_data, o_mem_req, o_mem_addr, o_mem_byte_en, o_mem_wr_en, o_mem_wr_data};
    endfunction

    // memory: accepts after a stall, answers after a delay (0 = same cycle as accept)
    initial begin : mem_resp
        int          stall_cnt;
        int          rv_cnt;
        int          rvd;
        bit          pend;
        bit          ready;
        logic [31:0] pend_data;
        stall_cnt = 0; rv_cnt = 0; pend = 0; pend_data = 0;
        i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rd_data = 0;
        forever begin
            @(posedge i_clk); #1;
            i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rd_data = 0;
            if (pend) begin
                if (rv_cnt == 0) begin
                    i_mem_rvalid = 1; i_mem_rd_data = pend_data; pend = 0;
                end else begin
                    rv_cnt--;
                end
            end else if (o_mem_req) begin
                ready = mem_rand ? ($urandom_range(0, 2) == 0) : (stall_cnt >= mem_gnt_delay);
                if (ready) begin
                    i_mem_gnt = 1;
                    stall_cnt = 0;
                    pend_data = mem_word(o_mem_addr);
                    rvd = mem_rand ? int'($urandom_range(0, 2)) : mem_rv_delay;
                    if (rvd == 0) begin
                        i_mem_rvalid = 1; i_mem_rd_data = pend_data;
                    end else begin
                        pend = 1; rv_cnt = rvd - 1;
                    end
                end else begin
                    stall_cnt++;
                end
            end
        end
    end

    task automatic drive_point();
        @(posedge i_clk); #1;
    endtask

    task automatic observe(input int ncyc);
        logic [66:0] cmd, prev_cmd;
        bit          prev_req, prev_gnt;
        ob_mreq = 0; ob_gnt_i = 0; ob_gnt_d = 0; ob_rv_i = 0; ob_rv_d = 0;
        ob_gntidx = -1; ob_gntidx_last = -1; ob_rvidx_i = -1; ob_rvidx_d = -1; ob_unstable = 0;
        ob_data_i = 'x; ob_data_d = 'x;
        snap_q.delete(); order_q.delete();
        prev_req = 0; prev_gnt = 0; prev_cmd = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge i_clk);
            cmd = {o_mem_addr, o_mem_byte_en, o_mem_wr_en, o_mem_wr_data};
            if (o_mem_req) begin
                ob_mreq++;
                if (prev_req && !prev_gnt && cmd != prev_cmd) ob_unstable++;
            end
            if (o_imem_gnt || o_dmem_gnt) begin
                snap_q.push_back(cmd);
                if (ob_gntidx < 0) ob_gntidx = c;
                ob_gntidx_last = c;
            end
            if (o_imem_gnt) begin
                ob_gnt_i++; order_q.push_back(0); i_imem_req = 0;
            end
            if (o_dmem_gnt) begin
                ob_gnt_d++; order_q.push_back(1);
                if (dmem_more > 0) begin
                    dmem_more--; i_dmem_addr = i_dmem_addr + 32'd4;
                end else begin
                    i_dmem_req = 0;
                end
            end
            if (o_imem_rvalid) begin
                ob_rv_i++; ob_data_i = o_imem_rd_data;
                if (ob_rvidx_i < 0) ob_rvidx_i = c;
            end
            if (o_dmem_rvalid) begin
                ob_rv_d++; ob_data_d = o_dmem_rd_data;
                if (ob_rvidx_d < 0) ob_rvidx_d = c;
            end
            prev_req = o_mem_req; prev_gnt = o_imem_gnt || o_dmem_gnt; prev_cmd = cmd;
        end
    endtask

    task automatic test_reset();
        i_reset = 1; i_imem_req = 0; i_imem_addr = 0; i_dmem_req = 0; i_dmem_addr = 0;
        i_dmem_byte_en = 0; i_dmem_wr_en = 0; i_dmem_wr_data = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        drive_point(); i_reset = 0;
        @(negedge i_clk);
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL post_reset_idle: got %h want 0", all_outs());
        end
    endtask

    task automatic test_single_fetch();
        logic [66:0] s;
        fixed_en = 1; fixed_data = 32'h00000013; mem_gnt_delay = 0; mem_rv_delay = 1;
        drive_point();
        i_imem_req = 1; i_imem_addr = 32'h1000;
        observe(8);
        fixed_en = 0;
        s = (snap_q.size() > 0) ? snap_q[0] : 'x;
        total++;
        if (s !== {32'h1000, 2'b10, 1'b0, 32'h0}) begin
            bad++; $display("FAIL fetch_cmd: got %h want %h", s, {32'h1000, 2'b10, 1'b0, 32'h0});
        end
        total++;
        if ({ob_mreq, ob_gntidx} !== {32'd1, 32'd1}) begin
            bad++; $display("FAIL fetch_req_cycles: got req=%0d gntidx=%0d want 1 1", ob_mreq, ob_gntidx);
        end
        total++;
        if ({ob_gnt_i, ob_rv_i, ob_rvidx_i, ob_data_i} !== {32'd1, 32'd1, 32'd3, 32'h13}) begin
            bad++; $display("FAIL fetch_resp: got gnt=%0d rv=%0d idx=%0d data=%h want 1 1 3 00000013",
                            ob_gnt_i, ob_rv_i, ob_rvidx_i, ob_data_i);
        end
        total++;
        if ({ob_gnt_d, ob_rv_d, o_dmem_rd_data} !== {32'd0, 32'd0, 32'd0}) begin
            bad++; $display("FAIL fetch_dmem_quiet: got gnt=%0d rv=%0d data=%h want 0 0 0",
                            ob_gnt_d, ob_rv_d, o_dmem_rd_data);
        end
    endtask

    task automatic test_simultaneous();
        logic [66:0] s0, s1;
        mem_gnt_delay = 0; mem_rv_delay = 1;
        drive_point();
        i_imem_req = 1; i_imem_addr = 32'h1004;
        i_dmem_req = 1; i_dmem_addr = 32'h2000; i_dmem_byte_en = 2'b10; i_dmem_wr_en = 0; i_dmem_wr_data = 0;
        observe(12);
        s0 = (snap_q.size() > 0) ? snap_q[0] : 'x;
        s1 = (snap_q.size() > 1) ? snap_q[1] : 'x;
        total++;
        if ({s0, s1} !== {32'h2000, 2'b10, 1'b0, 32'h0, 32'h1004, 2'b10, 1'b0, 32'h0}) begin
            bad++; $display("FAIL simul_order: got %h %h want dmem 2000 then imem 1004", s0, s1);
        end
        total++;
        if ({ob_data_d, ob_data_i, ob_rv_d, ob_rv_i} !==
            {mem_word(32'h2000), mem_word(32'h1004), 32'd1, 32'd1}) begin
            bad++; $display("FAIL simul_data: got d=%h i=%h rv=%0d/%0d want %h %h 1/1", ob_data_d, ob_data_i,
                            ob_rv_d, ob_rv_i, mem_word(32'h2000), mem_word(32'h1004));
        end
    endtask

    // relies on the run count having been cleared by the imem grant of the previous test
    task automatic test_back_to_back();
        int got_bits, exp_bits, exp_n;
        logic [66:0] s;
        mem_gnt_delay = 0; mem_rv_delay = 1;
        drive_point();
        i_imem_req = 1; i_imem_addr = 32'h1100;
        i_dmem_req = 1; i_dmem_addr = 32'h3000; i_dmem_byte_en = 2'b10; i_dmem_wr_en = 1;
        i_dmem_wr_data = 32'hCAFE0001; dmem_more = 5;
        observe(30);
        exp_bits = 0; exp_n = 0;
        for (int k = 0; k < MAX_RUN; k++) begin exp_bits |= (1 << exp_n); exp_n++; end
        exp_n++;
        for (int k = 0; k < 2; k++) begin exp_bits |= (1 << exp_n); exp_n++; end
        got_bits = 0;
        foreach (order_q[k]) got_bits |= (order_q[k] << k);
        total++;
        if ({order_q.size(), got_bits} !== {exp_n, exp_bits}) begin
            bad++; $display("FAIL starve_order: got n=%0d bits=%b want n=%0d bits=%b",
                            order_q.size(), got_bits, exp_n, exp_bits);
        end
        s = (snap_q.size() > MAX_RUN) ? snap_q[MAX_RUN] : 'x;
        total++;
        if (s !== {32'h1100, 2'b10, 1'b0, 32'h0}) begin
            bad++; $display("FAIL starve_imem_cmd: got %h want imem 1100", s);
        end
        total++;
        if ({ob_rv_d, ob_rv_i, ob_data_d} !== {32'd6, 32'd1, 32'd0}) begin
            bad++; $display("FAIL starve_resp: got rv_d=%0d rv_i=%0d data=%h want 6 1 0", ob_rv_d, ob_rv_i, ob_data_d);
        end
    endtask

    task automatic test_same_cycle();
        logic [66:0] s;
        mem_gnt_delay = 0; mem_rv_delay = 0;
        drive_point();
        i_dmem_req = 1; i_dmem_addr = 32'h2008; i_dmem_byte_en = 2'b01; i_dmem_wr_en = 1;
        i_dmem_wr_data = 32'hDEADBEEF; dmem_more = 1;
        observe(10);
        s = (snap_q.size() > 0) ? snap_q[0] : 'x;
        total++;
        if (s !== {32'h2008, 2'b01, 1'b1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL samecyc_cmd: got %h want %h", s, {32'h2008, 2'b01, 1'b1, 32'hDEADBEEF});
        end
        total++;
        if ({ob_rvidx_d, ob_data_d, ob_rv_i} !== {32'd2, 32'd0, 32'd0}) begin
            bad++; $display("FAIL samecyc_ack: got idx=%0d data=%h rv_i=%0d want 2 0 0", ob_rvidx_d, ob_data_d, ob_rv_i);
        end
        total++;
        if ({ob_gnt_d, ob_gntidx_last, ob_rv_d} !== {32'd2, 32'd3, 32'd2}) begin
            bad++; $display("FAIL samecyc_rearb: got gnt=%0d last=%0d rv=%0d want 2 3 2", ob_gnt_d, ob_gntidx_last, ob_rv_d);
        end
        mem_rv_delay = 1;
    endtask

    task automatic test_stall();
        logic [31:0] a;
        a = $urandom() & 32'hFFFFFFFC;
        mem_gnt_delay = 5; mem_rv_delay = 1;
        drive_point();
        i_dmem_req = 1; i_dmem_addr = a; i_dmem_byte_en = 2'b10; i_dmem_wr_en = 0; i_dmem_wr_data = 0;
        observe(12);
        mem_gnt_delay = 0;
        total++;
        if ({ob_mreq, ob_unstable, ob_gnt_d + ob_gnt_i, ob_gntidx} !== {32'd6, 32'd0, 32'd1, 32'd6}) begin
            bad++; $display("FAIL stall_hold: got req=%0d unstable=%0d gnts=%0d gntidx=%0d want 6 0 1 6",
                            ob_mreq, ob_unstable, ob_gnt_d + ob_gnt_i, ob_gntidx);
        end
        total++;
        if ({ob_rv_d, ob_data_d} !== {32'd1, mem_word(a)}) begin
            bad++; $display("FAIL stall_resp: got rv=%0d data=%h want 1 %h", ob_rv_d, ob_data_d, mem_word(a));
        end
    endtask

    task automatic test_reset_in_resp();
        bit got;
        mem_gnt_delay = 0; mem_rv_delay = 4;
        drive_point();
        i_imem_req = 1; i_imem_addr = 32'h1800;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge i_clk);
            if (o_imem_gnt) begin got = 1; i_imem_req = 0; end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL rst_resp_gnt: got no imem gnt want 1 within 10 cycles");
            i_imem_req = 0;
        end
        drive_point(); i_reset = 1;
        drive_point(); i_reset = 0;
        mem_rv_delay = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            total++;
            if (all_outs() !== '0) begin
                bad++; $display("FAIL rst_resp_quiet[%0d]: got %h want 0", c, all_outs());
            end
        end
        drive_point();
        i_imem_req = 1; i_imem_addr = 32'h1200;
        observe(8);
        total++;
        if ({ob_rv_i, ob_data_i, ob_rv_d} !== {32'd1, mem_word(32'h1200), 32'd0}) begin
            bad++; $display("FAIL rst_resp_next: got rv=%0d data=%h rv_d=%0d want 1 %h 0",
                            ob_rv_i, ob_data_i, ob_rv_d, mem_word(32'h1200));
        end
    endtask

    task automatic test_random();
        localparam int NI = 40;
        localparam int ND = 40;
        logic [31:0] exp_i[$];
        logic [31:0] exp_d[$];
        int rv_i, rv_d, run, cyc;
        rv_i = 0; rv_d = 0; run = 0; cyc = 0;
        mem_rand = 1;
        fork
            begin : drv_i
                for (int k = 0; k < NI; k++) begin
                    bit got;
                    repeat (1 + $urandom_range(0, 3)) drive_point();
                    i_imem_addr = $urandom() & 32'hFFFFFFFC; i_imem_req = 1; got = 0;
                    for (int t = 0; t < 200 && !got; t++) begin
                        @(negedge i_clk);
                        if (o_imem_gnt) begin got = 1; i_imem_req = 0; end
                    end
                    if (!got) begin
                        total++; bad++; i_imem_req = 0;
                        $display("FAIL rand_imem_timeout: got no gnt want gnt within 200 cycles");
                        break;
                    end
                end
            end
            begin : drv_d
                for (int k = 0; k < ND; k++) begin
                    bit got;
                    repeat (1 + $urandom_range(0, 2)) drive_point();
                    i_dmem_addr = $urandom(); i_dmem_byte_en = 2'($urandom_range(0, 2));
                    i_dmem_wr_en = 1'($urandom_range(0, 1)); i_dmem_wr_data = $urandom();
                    i_dmem_req = 1; got = 0;
                    for (int t = 0; t < 200 && !got; t++) begin
                        @(negedge i_clk);
                        if (o_dmem_gnt) begin got = 1; i_dmem_req = 0; end
                    end
                    if (!got) begin
                        total++; bad++; i_dmem_req = 0;
                        $display("FAIL rand_dmem_timeout: got no gnt want gnt within 200 cycles");
                        break;
                    end
                end
            end
            begin : mon
                while ((rv_i < NI || rv_d < ND) && cyc < 4000) begin
                    logic [31:0] e;
                    @(negedge i_clk); cyc++;
                    if (o_imem_gnt) begin
                        total++;
                        if ({o_mem_addr, o_mem_byte_en, o_mem_wr_en} !== {i_imem_addr, 2'b10, 1'b0}) begin
                            bad++; $display("FAIL rand_imem_cmd: got %h/%b/%b want %h/10/0",
                                            o_mem_addr, o_mem_byte_en, o_mem_wr_en, i_imem_addr);
                        end
                        exp_i.push_back(mem_word(i_imem_addr));
                        run = 0;
                    end
                    if (o_dmem_gnt) begin
                        total++;
                        if ({o_mem_addr, o_mem_byte_en, o_mem_wr_en, o_mem_wr_data} !==
                            {i_dmem_addr, i_dmem_byte_en, i_dmem_wr_en, i_dmem_wr_data}) begin
                            bad++; $display("FAIL rand_dmem_cmd: got %h/%b/%b/%h want %h/%b/%b/%h",
                                            o_mem_addr, o_mem_byte_en, o_mem_wr_en, o_mem_wr_data,
                                            i_dmem_addr, i_dmem_byte_en, i_dmem_wr_en, i_dmem_wr_data);
                        end
                        exp_d.push_back(i_dmem_wr_en ? 32'h0 : mem_word(i_dmem_addr));
                        if (i_imem_req) begin
                            run++;
                            total++;
                            if (run > MAX_RUN + 1) begin
                                bad++; $display("FAIL rand_starve: got %0d dmem grants over waiting imem want <= %0d",
                                                run, MAX_RUN + 1);
                            end
                        end else begin
                            run = 0;
                        end
                    end
                    if (o_imem_rvalid) begin
                        rv_i++; total++;
                        e = (exp_i.size() > 0) ? exp_i.pop_front() : 'x;
                        if (o_imem_rd_data !== e) begin
                            bad++; $display("FAIL rand_imem_data: got %h want %h", o_imem_rd_data, e);
                        end
                    end
                    if (o_dmem_rvalid) begin
                        rv_d++; total++;
                        e = (exp_d.size() > 0) ? exp_d.pop_front() : 'x;
                        if (o_dmem_rd_data !== e) begin
                            bad++; $display("FAIL rand_dmem_data: got %h want %h", o_dmem_rd_data, e);
                        end
                    end
                end
            end
        join
        mem_rand = 0;
        total++;
        if ({rv_i, rv_d, exp_i.size(), exp_d.size()} !== {NI, ND, 32'd0, 32'd0}) begin
            bad++; $display("FAIL rand_complete: got rv_i=%0d rv_d=%0d left=%0d/%0d want %0d %0d 0/0",
                            rv_i, rv_d, exp_i.size(), exp_d.size(), NI, ND);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_back_to_back();
        test_same_cycle();
        test_stall();
        test_reset_in_resp();
        test_random();
        repeat (4) @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
